// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared types, widths and truncation mask for the sequential partial-product multiplier
package pp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned PW_DEF = 2 * DW_DEF;

  // Ones everywhere except the TRUNC lowest columns, limited to the 2*DW product width.
  function automatic logic [63:0] trunc_mask(input int unsigned trunc, input int unsigned dw);
    logic [63:0] keep_hi;
    logic [63:0] keep_pw;
    keep_hi = ~64'd0 << trunc;
    keep_pw = (2 * dw >= 64) ? ~64'd0 : ~(~64'd0 << (2 * dw));
    return keep_hi & keep_pw;
  endfunction

endpackage

// File: rtl/pp_row.sv
// rtl/pp_row.sv - one shifted, column-truncated partial-product row
module pp_row
  import pp_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned TRUNC = 0,
  localparam int unsigned PW   = 2 * DW,
  localparam int unsigned CW   = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic [DW-1:0] muld,
  input  logic          mulr_bit,
  input  logic [CW-1:0] idx,
  output logic [PW-1:0] row
);

  localparam logic [63:0] MASK64 = trunc_mask(TRUNC, DW);
  localparam logic [PW-1:0] MASK = MASK64[PW-1:0];

  logic [PW-1:0] row_ext;

  always_comb begin
    row_ext = {{DW{1'b0}}, muld & {DW{mulr_bit}}};
    row     = (row_ext << idx) & MASK;
  end

endmodule

// File: rtl/pp_seq_mult.sv
// rtl/pp_seq_mult.sv - iterative unsigned multiplier, one partial-product row per cycle,
// valid/ready on operand and result sides
module pp_seq_mult
  import pp_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned TRUNC = 0,
  localparam int unsigned PW   = 2 * DW,
  localparam int unsigned CW   = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] muld,
  input  logic [DW-1:0] mulr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] prod,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] muld_q, muld_d;
  logic [DW-1:0] mulr_q, mulr_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] row;
  logic          accept;

  pp_row #(
    .DW   (DW),
    .TRUNC(TRUNC)
  ) u_row (
    .muld    (muld_q),
    .mulr_bit(mulr_q[cnt_q]),
    .idx     (cnt_q),
    .row     (row)
  );

  // DONE may hand off its result and take new operands in the same cycle.
  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign prod      = acc_q;

  always_comb begin
    state_d     = state_q;
    muld_d      = muld_q;
    mulr_d      = mulr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          muld_d      = muld;
          mulr_d      = mulr;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = ST_RUN;
          out_valid_d = 1'b0;
          busy_d      = 1'b1;
        end else if (state_q == ST_DONE && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + row;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      muld_q      <= '0;
      mulr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      muld_q      <= muld_d;
      mulr_q      <= mulr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pp_seq_mult.sv
// tb/tb_pp_seq_mult.sv - self-checking bench for pp_seq_mult (TRUNC=0 and TRUNC=4 instances in lockstep)
module tb_pp_seq_mult;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  muld = 8'd0;
  logic [7:0]  mulr = 8'd0;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready4, out_valid4, busy4;
  logic [15:0] prod0, prod4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pp_seq_mult #(.DW(DW), .TRUNC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .muld(muld), .mulr(mulr), .out_valid(out_valid0), .out_ready(out_ready),
    .prod(prod0), .busy(busy0)
  );

  pp_seq_mult #(.DW(DW), .TRUNC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .muld(muld), .mulr(mulr), .out_valid(out_valid4), .out_ready(out_ready),
    .prod(prod4), .busy(busy4)
  );

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  r;
    logic [15:0] e0;
    logic [15:0] e4;
    int          stall;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid0 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] d, input logic [7:0] r,
                        input logic [15:0] e0, input logic [15:0] e4, input int stall);
    int n;
    logic [15:0] held;
    muld = d;
    mulr = r;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("accept_ready", in_ready0, 1);
    tick();
    in_valid = 1'b0;
    muld = 8'($urandom);
    mulr = 8'($urandom);
    chk("busy_run", busy0, 1);
    wait_valid(n);
    chk("latency", n, DW + 1);
    chk("prod_t0", prod0, e0);
    chk("prod_t4", prod4, e4);
    chk("busy_done", busy0, 0);
    held = prod0;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_valid", out_valid0, 1);
      chk("hold_prod", prod0, held);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("idle_valid", out_valid0, 0);
    chk("idle_ready", in_ready0, 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_cnt;
    int got;
    int cyc;
    int bad_valid;
    logic presenting;
    logic [15:0] ex;
    logic [15:0] q[$];

    vecs[0]  = '{8'h03, 8'h03, 16'h0009, 16'h0000, 0};
    vecs[1]  = '{8'hFF, 8'hFF, 16'hFE01, 16'hFDD0, 5};
    vecs[2]  = '{8'h0F, 8'h01, 16'h000F, 16'h0000, 1};
    vecs[3]  = '{8'hFF, 8'h03, 16'h02FD, 16'h02E0, 0};
    vecs[4]  = '{8'h07, 8'h06, 16'h002A, 16'h0010, 2};
    vecs[5]  = '{8'h02, 8'h05, 16'h000A, 16'h0000, 0};
    vecs[6]  = '{8'hC8, 8'h64, 16'h4E20, 16'h4E20, 1};
    vecs[7]  = '{8'h00, 8'hFF, 16'h0000, 16'h0000, 0};
    vecs[8]  = '{8'hFF, 8'h00, 16'h0000, 16'h0000, 0};
    vecs[9]  = '{8'h80, 8'h80, 16'h4000, 16'h4000, 3};
    vecs[10] = '{8'h55, 8'hAA, 16'h3872, 16'h3860, 0};

    repeat (2) tick();
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_prod", prod0, 16'h0000);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].d, vecs[i].r, vecs[i].e0, vecs[i].e4, vecs[i].stall);

    // back-to-back: accept (2,5) in the DONE cycle of (7,6)
    muld = 8'd7; mulr = 8'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b_first_lat", n, DW + 1);
    chk("b2b_first_prod", prod0, 16'd42);
    muld = 8'd2; mulr = 8'd5; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready0, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid_drop", out_valid0, 0);
    wait_valid(n);
    chk("b2b_second_lat", n, DW + 1);
    chk("b2b_second_prod", prod0, 16'd10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset in the middle of RUN discards the result
    muld = 8'd200; mulr = 8'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid0, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_prod", prod0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", in_ready0, 1);
    bad_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid0) bad_valid++;
      tick();
    end
    chk("midrst_no_valid", bad_valid, 0);
    run_op(8'd200, 8'd100, 16'd20000, 16'd20000, 0);

    // randomized stream with stalls on both sides, TRUNC=0 checked in order
    acc_cnt = 0; got = 0; cyc = 0; presenting = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      if (!presenting && acc_cnt < 1000 && $urandom_range(3) != 0) begin
        muld = 8'($urandom);
        mulr = 8'($urandom);
        presenting = 1'b1;
      end
      in_valid = presenting;
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid0 && out_ready) begin
        got++;
        if (q.size() == 0) chk("rand_extra", 1, 0);
        else begin
          ex = q.pop_front();
          chk("rand_prod", prod0, ex);
        end
      end
      if (in_valid && in_ready0) begin
        q.push_back(16'(muld) * 16'(mulr));
        acc_cnt++;
        presenting = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_count", got, 1000);
    chk("rand_lockstep", out_valid4, out_valid0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
